register_wb_queue: RTL

- Parametrised write-back stage. Decodes the 4-bit write-back op into 1 or 2 register-file write lanes and buffers them in a DEPTH-entry in-order queue.
- Drains the queue to the register file under a ready handshake, so execute is never blocked by a busy register file until the queue fills.
- Sits between execute and the register-file write ports.
- Adds over the single-cycle write-back stage: back-pressure, same-address lane collision resolution, illegal-op flagging, and optional forwarding.

---
 rtl/register_wb_pkg.sv | 57 +++++
 rtl/register_wb_queue_fifo.sv | 43 ++++
 rtl/register_wb_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/register_wb_pkg.sv
// Shared write-back definitions: op codes, lane masks, queue entry layout and op decode.
// The entry layout fixes the register data/address widths used by register_wb_queue.
package register_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [3:0] WB_NOP       = 4'd0;
  localparam logic [3:0] WB_R1_A1     = 4'd1;
  localparam logic [3:0] WB_R1_A2     = 4'd2;
  localparam logic [3:0] WB_R1_R2A    = 4'd3;
  localparam logic [3:0] WB_R2_A1     = 4'd4;
  localparam logic [3:0] WB_R2_A2     = 4'd5;
  localparam logic [3:0] WB_R2_R1A    = 4'd6;
  localparam logic [3:0] WB_PAIR      = 4'd7;
  localparam logic [3:0] WB_PAIR_SWAP = 4'd8;

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_1    = 2'b01;
  localparam logic [1:0] LANE_2    = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  typedef struct packed {
    logic [1:0]           mask;
    logic [WB_DATA_W-1:0] d1;
    logic [WB_DATA_W-1:0] d2;
    logic [WB_ADDR_W-1:0] a1;
    logic [WB_ADDR_W-1:0] a2;
  } wb_entry_t;

  // Unused lanes stay zero so the queue never carries stale data/addresses.
  function automatic wb_entry_t wb_decode(input logic [3:0] op,
                                          input logic [WB_DATA_W-1:0] r1,
                                          input logic [WB_DATA_W-1:0] r2,
                                          input logic [WB_ADDR_W-1:0] a1,
                                          input logic [WB_ADDR_W-1:0] a2);
    wb_entry_t e;
    e = '0;
    case (op)
      WB_R1_A1:     begin e.mask = LANE_1; e.d1 = r1; e.a1 = a1; end
      WB_R1_A2:     begin e.mask = LANE_1; e.d1 = r1; e.a1 = a2; end
      WB_R1_R2A:    begin e.mask = LANE_1; e.d1 = r1; e.a1 = r2[WB_ADDR_W-1:0]; end
      WB_R2_A1:     begin e.mask = LANE_1; e.d1 = r2; e.a1 = a1; end
      WB_R2_A2:     begin e.mask = LANE_1; e.d1 = r2; e.a1 = a2; end
      WB_R2_R1A:    begin e.mask = LANE_1; e.d1 = r2; e.a1 = r1[WB_ADDR_W-1:0]; end
      WB_PAIR:      begin e.mask = LANE_BOTH; e.d1 = r1; e.a1 = a1; e.d2 = r2; e.a2 = a2; end
      WB_PAIR_SWAP: begin e.mask = LANE_BOTH; e.d1 = r1; e.a1 = a2; e.d2 = r2; e.a2 = a1; end
      default:      e = '0;
    endcase
    return e;
  endfunction

  function automatic logic wb_op_illegal(input logic [3:0] op);
    return op > WB_PAIR_SWAP;
  endfunction

endpackage

// File: rtl/register_wb_queue_fifo.sv
// Generic DEPTH-entry in-order FIFO of flat W-bit entries with occupancy count.
// Storage and read pointer are exported so the owner can search pending entries.
module wb_entry_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [W-1:0]                      push_data,
  input  logic                              pop,
  output logic [W-1:0]                      head,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0][W-1:0]           mem,
  output logic [$clog2(DEPTH)-1:0]          rd_ptr
);

  logic [$clog2(DEPTH)-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/register_wb_queue.sv
// Queued write-back stage: decodes ops into 1-2 register-file lanes and drains them in order.
// Define WB_FWD_EN to build the pending-write forwarding lookup on fwd_addr.
module register_wb_queue
  import register_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op,
  input  logic [DATA_W-1:0]        r1,
  input  logic [DATA_W-1:0]        r2,
  input  logic [ADDR_W-1:0]        a1,
  input  logic [ADDR_W-1:0]        a2,
  input  logic                     rf_ready,
  output logic [DATA_W-1:0]        wr1,
  output logic [DATA_W-1:0]        wr2,
  output logic [ADDR_W-1:0]        wa1,
  output logic [ADDR_W-1:0]        wa2,
  output logic [1:0]               write,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(wb_entry_t);

  wb_entry_t                  enq;
  wb_entry_t                  hd;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic                       empty;
  logic [EW-1:0]              head_bits;
  logic [DEPTH-1:0][EW-1:0]   mem;
  logic [$clog2(DEPTH)-1:0]   rd_ptr;

  assign in_ready = count < CW'(DEPTH);
  assign accept   = in_valid && in_ready;

  // Same-address pair: lane2 wins, lane1 is cleared entirely.
  always_comb begin
    enq = wb_decode(op, r1, r2, a1, a2);
    if (enq.mask == LANE_BOTH && enq.a1 == enq.a2) begin
      enq.mask = LANE_2;
      enq.d1   = '0;
      enq.a1   = '0;
    end
  end

  assign push = accept && (enq.mask != LANE_NONE);

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= accept && wb_op_illegal(op);
  end

  wb_entry_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enq),
    .pop       (pop),
    .head      (head_bits),
    .count     (count),
    .mem       (mem),
    .rd_ptr    (rd_ptr)
  );

  assign empty = (count == '0);
  assign hd    = head_bits;

  always_comb begin
    write = LANE_NONE;
    wr1   = '0;
    wr2   = '0;
    wa1   = '0;
    wa2   = '0;
    if (!empty) begin
      write = hd.mask;
      wr1   = hd.d1;
      wr2   = hd.d2;
      wa1   = hd.a1;
      wa2   = hd.a2;
    end
  end

  assign pop = (write != LANE_NONE) && rf_ready;

`ifdef WB_FWD_EN
  wb_entry_t                fwd_e;
  logic [$clog2(DEPTH)-1:0] fwd_idx;

  // Walk oldest to youngest so later matches (and lane2 within an entry) override.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_e    = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + ($clog2(DEPTH))'(k);
      fwd_e   = mem[fwd_idx];
      if (CW'(k) < count) begin
        if (fwd_e.mask[0] && fwd_e.a1 == fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = fwd_e.d1;
        end
        if (fwd_e.mask[1] && fwd_e.a2 == fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = fwd_e.d2;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr, mem, rd_ptr};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
